p2_dir_sequencer: RTL and testbench
===================================

// Module: p2_dir_sequencer
// PURPOSE
//  Sequences the p2 nibble bus transceiver (p2_buf_oe, p2_buf_dir) and the FPGA p2 pin tri-state enable.
//  The goal is that the FPGA and the bus driver never drive p2 at the same time.
//  It sits between ioexp (drive_req = its p2_oe) and the top-level pins, replacing the combinational dir/oe assigns.
//  Each direction change inserts break-before-make dead time and a settle time.
//  A watchdog bounds how long the FPGA may hold the bus.
// PARAMETERS
//  DEAD_CYCLES    2     clk cycles buffer is disabled before dir/pin-drive changes (1..15)
//  SETTLE_CYCLES  1     clk cycles after dir/pin-drive change before buffer re-enabled (1..15)
//  MAX_DRIVE      4096  max consecutive clk cycles in DRIVE before watchdog fault (>=16)
// PORTS
//  clk          in   1  system clock, 7.3728 MHz
//  nrst         in   1  asynchronous active-low reset
//  drive_req    in   1  ioexp wants to drive p2 (level)
//  drive_allow  in   1  prog pin state (synchronised); 1 = meter permits IB to drive
//  drive_ack    out  1  1 only in DRIVE: p2o is on the wire
//  p2_pin_oe    out  1  FPGA p2 pad output enable (p2 = p2_pin_oe ? p2o : 'z)
//  p2_buf_oe    out  1  transceiver enable, active-low (1 = buffer isolated)
//  p2_buf_dir   out  1  transceiver direction, 0 = bus->FPGA, 1 = FPGA->bus
//  wd_fault     out  1  sticky watchdog fault; cleared only when drive_req = 0 in READ
// BEHAVIOUR
//  Reset (nrst=0, async): state=RST_HOLD, cnt=0.
//    p2_buf_oe=1, p2_buf_dir=0, p2_pin_oe=0, drive_ack=0, wd_fault=0.
//  All outputs are registered, decoded from state. There is no combinational path from inputs to outputs.
//  want = drive_req & drive_allow & ~wd_fault.
//  States and outputs (oe, dir, pin_oe, ack):
//   RST_HOLD  (1,0,0,0): count DEAD_CYCLES, then -> READ
//   READ      (0,0,0,0): if want -> R2W_OFF, cnt=0
//   R2W_OFF   (1,0,0,0): after DEAD_CYCLES -> R2W_SET
//                        if want drops first -> W2R_SET (dir is still 0, skip dead time)
//   R2W_SET   (1,1,1,0): after SETTLE_CYCLES -> DRIVE
//                        if want drops -> W2R_OFF
//   DRIVE     (0,1,1,1): if ~want -> W2R_OFF
//                        if wd_cnt reaches MAX_DRIVE-1 -> set wd_fault, -> W2R_OFF
//   W2R_OFF   (1,1,1,0): after DEAD_CYCLES -> W2R_SET; this is the only exit from dir=1
//   W2R_SET   (1,0,0,0): after SETTLE_CYCLES -> READ
//  Invariants:
//   - p2_buf_dir and p2_pin_oe change only in cycles where p2_buf_oe has been 1 for >= DEAD_CYCLES cycles.
//   - p2_buf_oe returns to 0 only after dir/pin_oe have been stable for SETTLE_CYCLES cycles.
//  Latency:
//   - read->drive: drive_ack rises DEAD+SETTLE+1 cycles after want rises (defaults: 4).
//   - drive->read: p2_buf_oe=0 with dir=0 DEAD+SETTLE+1 cycles after want falls.
//  Phase counter: 4-bit cnt, reset to 0 on every state entry.
//    A phase ends when cnt == N-1.
//  Watchdog counter: wd_cnt is $clog2(MAX_DRIVE) bits wide.
//    It is cleared on DRIVE entry, increments each DRIVE cycle, and saturates (never wraps).
//  Simultaneous events:
//   - Watchdog expiry and want falling in the same cycle: fault is still set, -> W2R_OFF.
//   - drive_allow falling in any state overrides drive_req.
//  wd_fault clears in READ when drive_req = 0. A new request is honoured no earlier than the next cycle.
//  Reset mid-operation: outputs go to reset values immediately (async). The bus is isolated.
// TESTING
//  1 Reset release, defaults:
//    p2_buf_oe=1 for 2 cycles, then 0; dir=0, pin_oe=0, ack=0 throughout.
//  2 drive_req=1, drive_allow=1 in READ:
//    oe=1 @+1; dir=pin_oe=1 @+3; oe=0, ack=1 @+4.
//    Drop drive_req: ack=0, oe=1 @+1; dir=0 @+3; oe=0 @+4.
//  3 drive_allow falls mid-R2W_SET:
//    -> W2R_OFF; dir held 1 for 2 dead cycles, then 0; ack never asserts.
//  4 MAX_DRIVE=16, hold want:
//    ack high exactly 16 cycles; wd_fault=1; bus returns to READ.
//    drive_req stays 1 -> no re-drive.
//    drive_req=0 -> wd_fault clears.
//  5 Pulse drive_req for 1 cycle in READ:
//    R2W_OFF -> W2R_SET -> READ; dir never 1; no contention.
//  6 Assert nrst=0 in DRIVE:
//    p2_buf_oe=1, dir=0, pin_oe=0 in the same cycle, without a clock edge.
//  Assertion, all tests: never (p2_buf_oe==0 && p2_pin_oe != p2_buf_dir).

Source files
------------

// File: rtl/p2_dir_sequencer_if.sv
// Signal bundle between ioexp and the p2 direction sequencer.
// drive_req is a level request held by ioexp. drive_ack is high only while the FPGA owns the wire.
// A request is not consumed by ack; dropping drive_req (or drive_allow) starts the release sequence.
interface p2_dir_sequencer_if;
   logic       drive_req;
   logic       drive_allow;
   logic       drive_ack;
   logic       p2_pin_oe;
   logic       p2_buf_oe;
   logic       p2_buf_dir;
   logic       wd_fault;
   logic [2:0] dbg_state;

   modport master (
      output drive_req, drive_allow,
      input  drive_ack, p2_pin_oe, p2_buf_oe, p2_buf_dir, wd_fault, dbg_state
   );

   modport slave (
      input  drive_req, drive_allow,
      output drive_ack, p2_pin_oe, p2_buf_oe, p2_buf_dir, wd_fault, dbg_state
   );
endinterface

// File: rtl/p2_dir_sequencer.sv
// Break-before-make sequencer for the p2 transceiver and FPGA pad enable, with a drive watchdog.
// Outputs are registered decodes of the next state, so they track state_q with no input-to-output path.
module p2_dir_sequencer #(
   parameter int DEAD_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_DRIVE     = 4096
) (
   input logic                clk,
   input logic                nrst,
   p2_dir_sequencer_if.slave  bus
);
   localparam int WD_W = $clog2(MAX_DRIVE);
   localparam logic [3:0]      DEAD_LAST   = 4'(DEAD_CYCLES - 1);
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST     = WD_W'(MAX_DRIVE - 1);

   typedef enum logic [2:0] {
      RST_HOLD = 3'd0,
      READ     = 3'd1,
      R2W_OFF  = 3'd2,
      R2W_SET  = 3'd3,
      DRIVE    = 3'd4,
      W2R_OFF  = 3'd5,
      W2R_SET  = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            wd_fault_q, wd_fault_d;
   logic            oe_q, dir_q, pin_q, ack_q;
   logic            oe_d, dir_d, pin_d, ack_d;
   logic            want, dead_done, settle_done;

   assign want        = bus.drive_req & bus.drive_allow & ~wd_fault_q;
   assign dead_done   = (cnt_q == DEAD_LAST);
   assign settle_done = (cnt_q == SETTLE_LAST);

   always_comb begin
      state_d    = state_q;
      wd_cnt_d   = wd_cnt_q;
      wd_fault_d = wd_fault_q;
      case (state_q)
         RST_HOLD: if (dead_done) state_d = READ;
         READ: begin
            if (!bus.drive_req) wd_fault_d = 1'b0;
            if (want) state_d = R2W_OFF;
         end
         R2W_OFF: begin
            // dir never left 0 here, so an aborted request skips the dead phase
            if (!want)          state_d = W2R_SET;
            else if (dead_done) state_d = R2W_SET;
         end
         R2W_SET: begin
            if (!want) state_d = W2R_OFF;
            else if (settle_done) begin
               state_d  = DRIVE;
               wd_cnt_d = '0;
            end
         end
         DRIVE: begin
            if (wd_cnt_q == WD_LAST) begin
               wd_fault_d = 1'b1;
               state_d    = W2R_OFF;
            end else if (!want) begin
               state_d = W2R_OFF;
            end
            if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + 1'b1;
         end
         W2R_OFF: if (dead_done)   state_d = W2R_SET;
         W2R_SET: if (settle_done) state_d = READ;
         default: state_d = RST_HOLD;
      endcase

      if (state_d != state_q)  cnt_d = 4'd0;
      else if (cnt_q == 4'hF)  cnt_d = cnt_q;
      else                     cnt_d = cnt_q + 4'd1;
   end

   always_comb begin
      oe_d  = 1'b1;
      dir_d = 1'b0;
      pin_d = 1'b0;
      ack_d = 1'b0;
      case (state_d)
         READ: oe_d = 1'b0;
         R2W_SET, W2R_OFF: begin
            dir_d = 1'b1;
            pin_d = 1'b1;
         end
         DRIVE: begin
            oe_d  = 1'b0;
            dir_d = 1'b1;
            pin_d = 1'b1;
            ack_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= RST_HOLD;
         cnt_q      <= 4'd0;
         wd_cnt_q   <= '0;
         wd_fault_q <= 1'b0;
         oe_q       <= 1'b1;
         dir_q      <= 1'b0;
         pin_q      <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wd_cnt_q   <= wd_cnt_d;
         wd_fault_q <= wd_fault_d;
         oe_q       <= oe_d;
         dir_q      <= dir_d;
         pin_q      <= pin_d;
         ack_q      <= ack_d;
      end
   end

   assign bus.p2_buf_oe  = oe_q;
   assign bus.p2_buf_dir = dir_q;
   assign bus.p2_pin_oe  = pin_q;
   assign bus.drive_ack  = ack_q;
   assign bus.wd_fault   = wd_fault_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_p2_dir_sequencer.sv
// Directed bench for p2_dir_sequencer: reset, handover latency, aborts, watchdog, async reset.
module tb_p2_dir_sequencer;
   localparam logic [2:0] S_RST = 3'd0, S_READ = 3'd1, S_R2W_OFF = 3'd2, S_W2R_SET = 3'd6;
   // outs = {p2_buf_oe, p2_buf_dir, p2_pin_oe, drive_ack}
   localparam logic [3:0] O_ISO = 4'b1000, O_READ = 4'b0000, O_SW = 4'b1110, O_DRV = 4'b0111;

   logic clk = 1'b0;
   logic nrst;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] outs;

   p2_dir_sequencer_if bus();

   p2_dir_sequencer #(.DEAD_CYCLES(2), .SETTLE_CYCLES(1), .MAX_DRIVE(16)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign outs = {bus.p2_buf_oe, bus.p2_buf_dir, bus.p2_pin_oe, bus.drive_ack};

   always @(negedge clk) begin
      if (nrst === 1'b1) begin
         checks++;
         if (bus.p2_buf_oe === 1'b0 && bus.p2_pin_oe !== bus.p2_buf_dir) begin
            errors++;
            $display("FAIL contention: oe=%b pin_oe=%b dir=%b", bus.p2_buf_oe, bus.p2_pin_oe, bus.p2_buf_dir);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b1;
      bus.drive_req = 1'b0;
      bus.drive_allow = 1'b1;
      #1 nrst = 1'b0;
      #2;
      checks++;
      if (outs !== O_ISO || bus.wd_fault !== 1'b0) begin
         errors++; $display("FAIL reset_async: outs=%b wd=%b want outs=%b wd=0", outs, bus.wd_fault, O_ISO);
      end
      @(posedge clk); #1 nrst = 1'b1;
      checks++;
      if (outs !== O_ISO || bus.dbg_state !== S_RST) begin
         errors++; $display("FAIL reset_hold0: outs=%b st=%0d want %b st=%0d", outs, bus.dbg_state, O_ISO, S_RST);
      end
      step();
      checks++;
      if (outs !== O_ISO) begin
         errors++; $display("FAIL reset_hold1: outs=%b want %b", outs, O_ISO);
      end
      step();
      checks++;
      if (outs !== O_READ || bus.dbg_state !== S_READ) begin
         errors++; $display("FAIL reset_read: outs=%b st=%0d want %b st=%0d", outs, bus.dbg_state, O_READ, S_READ);
      end
   endtask

   task automatic test_read_drive();
      logic [3:0] up [6];
      logic [3:0] dn [4];
      up = '{O_ISO, O_ISO, O_SW, O_DRV, O_DRV, O_DRV};
      dn = '{O_SW, O_SW, O_ISO, O_READ};
      bus.drive_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (outs !== up[i]) begin
            errors++; $display("FAIL r2w_seq[%0d]: outs=%b want %b", i, outs, up[i]);
         end
      end
      bus.drive_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (outs !== dn[i]) begin
            errors++; $display("FAIL w2r_seq[%0d]: outs=%b want %b", i, outs, dn[i]);
         end
      end
   endtask

   task automatic test_allow_fall();
      logic [3:0] up [3];
      logic [3:0] dn [4];
      up = '{O_ISO, O_ISO, O_SW};
      dn = '{O_SW, O_SW, O_ISO, O_READ};
      bus.drive_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (outs !== up[i]) begin
            errors++; $display("FAIL allow_up[%0d]: outs=%b want %b", i, outs, up[i]);
         end
      end
      bus.drive_allow = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (outs !== dn[i]) begin
            errors++; $display("FAIL allow_dn[%0d]: outs=%b want %b", i, outs, dn[i]);
         end
      end
      bus.drive_req = 1'b0;
      bus.drive_allow = 1'b1;
      step();
      checks++;
      if (outs !== O_READ) begin
         errors++; $display("FAIL allow_idle: outs=%b want %b", outs, O_READ);
      end
   endtask

   task automatic test_watchdog();
      int ack_n = 0;
      bus.drive_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.drive_ack === 1'b1) ack_n++;
      end
      checks++;
      if (ack_n != 16) begin
         errors++; $display("FAIL wd_ack_len: ack cycles=%0d want 16", ack_n);
      end
      checks++;
      if (bus.wd_fault !== 1'b1 || outs !== O_READ || bus.dbg_state !== S_READ) begin
         errors++; $display("FAIL wd_fault_read: wd=%b outs=%b st=%0d want wd=1 outs=%b st=%0d",
                            bus.wd_fault, outs, bus.dbg_state, O_READ, S_READ);
      end
      bus.drive_req = 1'b0;
      step();
      checks++;
      if (bus.wd_fault !== 1'b0) begin
         errors++; $display("FAIL wd_clear: wd=%b want 0", bus.wd_fault);
      end
   endtask

   task automatic test_wd_and_drop();
      int ack_n = 0;
      bus.drive_req = 1'b1;
      for (int i = 0; i < 30 && ack_n < 16; i++) begin
         step();
         if (bus.drive_ack === 1'b1) ack_n++;
      end
      checks++;
      if (ack_n != 16) begin
         errors++; $display("FAIL wd_drop_timeout: ack cycles=%0d want 16", ack_n);
      end
      bus.drive_req = 1'b0;
      step();
      checks++;
      if (outs !== O_SW || bus.wd_fault !== 1'b1) begin
         errors++; $display("FAIL wd_drop_same: outs=%b wd=%b want %b wd=1", outs, bus.wd_fault, O_SW);
      end
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (outs !== O_READ || bus.wd_fault !== 1'b0) begin
         errors++; $display("FAIL wd_drop_recover: outs=%b wd=%b want %b wd=0", outs, bus.wd_fault, O_READ);
      end
   endtask

   task automatic test_pulse();
      bus.drive_req = 1'b1;
      step();
      checks++;
      if (outs !== O_ISO || bus.dbg_state !== S_R2W_OFF) begin
         errors++; $display("FAIL pulse_off: outs=%b st=%0d want %b st=%0d", outs, bus.dbg_state, O_ISO, S_R2W_OFF);
      end
      bus.drive_req = 1'b0;
      step();
      checks++;
      if (outs !== O_ISO || bus.dbg_state !== S_W2R_SET) begin
         errors++; $display("FAIL pulse_set: outs=%b st=%0d want %b st=%0d", outs, bus.dbg_state, O_ISO, S_W2R_SET);
      end
      step();
      checks++;
      if (outs !== O_READ || bus.dbg_state !== S_READ) begin
         errors++; $display("FAIL pulse_read: outs=%b st=%0d want %b st=%0d", outs, bus.dbg_state, O_READ, S_READ);
      end
   endtask

   task automatic test_reset_mid();
      bus.drive_req = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (outs !== O_DRV) begin
         errors++; $display("FAIL mid_drive: outs=%b want %b", outs, O_DRV);
      end
      #2 nrst = 1'b0;
      #1;
      checks++;
      if (outs !== O_ISO || bus.dbg_state !== S_RST) begin
         errors++; $display("FAIL mid_reset: outs=%b st=%0d want %b st=%0d", outs, bus.dbg_state, O_ISO, S_RST);
      end
      bus.drive_req = 1'b0;
      @(posedge clk); #1 nrst = 1'b1;
      step();
      step();
      checks++;
      if (outs !== O_READ) begin
         errors++; $display("FAIL mid_recover: outs=%b want %b", outs, O_READ);
      end
   endtask

   initial begin
      test_reset();
      test_read_drive();
      test_allow_fall();
      test_watchdog();
      test_wd_and_drop();
      test_pulse();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
